uart_sm4_frame_ctrl: RTL and testbench

//  Sequences the UART byte receiver into SM4 block transfers. Edge-detects the

---
 rtl/uart_sm4_frame_ctrl_if.sv | 23 ++
 rtl/uart_sm4_frame_ctrl.sv | 162 ++++++++++++++++
 tb/tb_uart_sm4_frame_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_sm4_frame_ctrl_if.sv
// Byte-receiver input and block handshake bundle for the UART-to-SM4 frame controller.
// master is the controller side; slave is the receiver/consumer side.
interface uart_sm4_frame_ctrl_if;
    logic [7:0]   rx_pdata;
    logic         rx_pdvalid;
    logic [127:0] blk_data;
    logic [1:0]   blk_mode;
    logic         blk_valid;
    logic         blk_ready;
    logic         busy;
    logic         err_pulse;
    logic [1:0]   err_code;

    modport master (
        input  rx_pdata, rx_pdvalid, blk_ready,
        output blk_data, blk_mode, blk_valid, busy, err_pulse, err_code
    );

    modport slave (
        output rx_pdata, rx_pdvalid, blk_ready,
        input  blk_data, blk_mode, blk_valid, busy, err_pulse, err_code
    );
endinterface

// File: rtl/uart_sm4_frame_ctrl.sv
// Parses header/mode/16-byte frames from the UART byte receiver into 128-bit SM4 blocks,
// with inter-byte timeout, bad-mode and overrun error reporting.
module uart_sm4_frame_ctrl #(
    parameter int unsigned CLK_F        = 50000000,
    parameter int unsigned UART_B       = 9600,
    parameter int unsigned TIMEOUT_BYTS = 4,
    parameter logic [7:0]  HDR_BYTE     = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    uart_sm4_frame_ctrl_if.master  bus
);

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned BLK_W   = 128;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned MODE_W  = 2;
    localparam int unsigned TMO_LIM = TIMEOUT_BYTS * 10 * (CLK_F / UART_B);
    localparam int unsigned TMO_W   = $clog2(TMO_LIM + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MODE = 2'd1,
        DATA = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [1:0] ERR_MODE = 2'd1;
    localparam logic [1:0] ERR_TMO  = 2'd2;
    localparam logic [1:0] ERR_OVR  = 2'd3;

    state_t              state, state_nxt;
    logic                rx_pdvalid_d;
    logic                byte_stb;
    logic                mode_ok;
    logic                tmo_hit;
    logic                tmo_run;
    logic                accept;
    logic [BLK_W-1:0]    shreg;
    logic [MODE_W-1:0]   mode_q;
    logic [CNT_W-1:0]    byte_cnt;
    logic [TMO_W-1:0]    tmo_cnt;

    logic                blk_valid_q, blk_valid_nxt;
    logic                busy_q, busy_nxt;
    logic                err_pulse_q, err_pulse_nxt;
    logic [1:0]          err_code_q, err_code_nxt;

    assign byte_stb = bus.rx_pdvalid & ~rx_pdvalid_d;
    assign mode_ok  = (bus.rx_pdata <= 8'd2);
    assign tmo_hit  = (tmo_cnt == TMO_W'(TMO_LIM));
    assign accept   = blk_valid_q & bus.blk_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; an arriving byte always takes priority over timeout expiry
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (byte_stb && (bus.rx_pdata == HDR_BYTE)) state_nxt = MODE;
            MODE: begin
                if (byte_stb)     state_nxt = mode_ok ? DATA : IDLE;
                else if (tmo_hit) state_nxt = IDLE;
            end
            DATA: begin
                if (byte_stb) begin
                    if (byte_cnt == CNT_W'(15)) state_nxt = HOLD;
                end else if (tmo_hit) begin
                    state_nxt = IDLE;
                end
            end
            HOLD:    if (accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered status outputs
    always_comb begin
        err_pulse_nxt = 1'b0;
        err_code_nxt  = err_code_q;
        blk_valid_nxt = (state_nxt == HOLD);
        busy_nxt      = (state_nxt != IDLE);
        case (state)
            MODE: begin
                if (byte_stb && !mode_ok) begin
                    err_pulse_nxt = 1'b1;
                    err_code_nxt  = ERR_MODE;
                end else if (!byte_stb && tmo_hit) begin
                    err_pulse_nxt = 1'b1;
                    err_code_nxt  = ERR_TMO;
                end
            end
            DATA: begin
                if (!byte_stb && tmo_hit) begin
                    err_pulse_nxt = 1'b1;
                    err_code_nxt  = ERR_TMO;
                end
            end
            HOLD: begin
                if (byte_stb) begin
                    err_pulse_nxt = 1'b1;
                    err_code_nxt  = ERR_OVR;
                end
            end
            default: ;
        endcase
    end

    // Timeout counter only advances while idling inside MODE/DATA
    assign tmo_run = ((state == MODE) || (state == DATA)) && (state_nxt == state) && !byte_stb;

    // Byte capture, frame assembly and timeout datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_pdvalid_d <= 1'b0;
            shreg        <= '0;
            mode_q       <= '0;
            byte_cnt     <= '0;
            tmo_cnt      <= '0;
        end else begin
            rx_pdvalid_d <= bus.rx_pdvalid;
            if ((state == MODE) && byte_stb && mode_ok) begin
                mode_q   <= bus.rx_pdata[MODE_W-1:0];
                byte_cnt <= '0;
            end
            if ((state == DATA) && byte_stb) begin
                shreg    <= {shreg[BLK_W-BYTE_W-1:0], bus.rx_pdata};
                byte_cnt <= byte_cnt + CNT_W'(1);
            end
            if (!tmo_run)      tmo_cnt <= '0;
            else if (!tmo_hit) tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    // Status output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_pulse_q <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            blk_valid_q <= blk_valid_nxt;
            busy_q      <= busy_nxt;
            err_pulse_q <= err_pulse_nxt;
            err_code_q  <= err_code_nxt;
        end
    end

    // shreg does not shift outside DATA, so it is stable for the whole HOLD window
    assign bus.blk_data  = shreg;
    assign bus.blk_mode  = mode_q;
    assign bus.blk_valid = blk_valid_q;
    assign bus.busy      = busy_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_uart_sm4_frame_ctrl.sv
// Randomized frame-level bench for uart_sm4_frame_ctrl, checked against expected blocks,
// modes and error codes derived from the frame protocol rules.
module tb_uart_sm4_frame_ctrl;

    localparam int unsigned CLK_F        = 1000;
    localparam int unsigned UART_B       = 100;
    localparam int unsigned TIMEOUT_BYTS = 4;
    localparam int          TMO_LIM      = TIMEOUT_BYTS * 10 * (CLK_F / UART_B);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_sm4_frame_ctrl_if bus ();

    uart_sm4_frame_ctrl #(
        .CLK_F        (CLK_F),
        .UART_B       (UART_B),
        .TIMEOUT_BYTS (TIMEOUT_BYTS),
        .HDR_BYTE     (8'hA5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int err_hi = 0;
    int last_set_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.err_pulse) err_hi <= err_hi + 1;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pack_blk(input logic [7:0] pl [16]);
        logic [127:0] b;
        b = '0;
        for (int i = 0; i < 16; i++) b[127-8*i -: 8] = pl[i];
        return b;
    endfunction

    // One receiver byte: level high for 'hold' cycles, then low for at least one cycle
    task automatic drive_byte(input logic [7:0] b, input int hold, input int gap);
        @(posedge clk); #1;
        bus.rx_pdata   = b;
        bus.rx_pdvalid = 1'b1;
        last_set_cyc   = cyc;
        repeat (hold) @(posedge clk);
        #1;
        bus.rx_pdata   = 8'h00;
        bus.rx_pdvalid = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic send_frame(input logic [1:0] mode, input logic [7:0] pl [16],
                              input int h_lo, input int h_hi, input int g_hi, input string tag);
        logic [127:0] exp_blk;
        exp_blk = pack_blk(pl);
        drive_byte(8'hA5, $urandom_range(h_hi, h_lo), $urandom_range(g_hi, 0));
        drive_byte(8'(mode), $urandom_range(h_hi, h_lo), $urandom_range(g_hi, 0));
        for (int i = 0; i < 15; i++)
            drive_byte(pl[i], $urandom_range(h_hi, h_lo), $urandom_range(g_hi, 0));
        @(posedge clk); #1;
        bus.rx_pdata   = pl[15];
        bus.rx_pdvalid = 1'b1;
        @(negedge clk);
        check_val({tag, "_valid_pre"}, 128'(bus.blk_valid), 128'(0));
        @(negedge clk);
        check_val({tag, "_valid"}, 128'(bus.blk_valid), 128'(1));
        check_val({tag, "_data"},  bus.blk_data, exp_blk);
        check_val({tag, "_mode"},  128'(bus.blk_mode), 128'(mode));
        check_val({tag, "_busy"},  128'(bus.busy), 128'(1));
        repeat ($urandom_range(h_hi, h_lo)) @(posedge clk);
        #1;
        bus.rx_pdata   = 8'h00;
        bus.rx_pdvalid = 1'b0;
    endtask

    task automatic accept_blk(input int delay, input string tag);
        repeat (delay) @(posedge clk);
        #1 bus.blk_ready = 1'b1;
        @(posedge clk); #1 bus.blk_ready = 1'b0;
        @(negedge clk);
        check_val({tag, "_acc_valid"}, 128'(bus.blk_valid), 128'(0));
        check_val({tag, "_acc_busy"},  128'(bus.busy), 128'(0));
    endtask

    task automatic rand_payload(output logic [7:0] pl [16]);
        for (int i = 0; i < 16; i++) pl[i] = 8'($urandom_range(255, 0));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "bench time limit expired");
    end

    initial begin
        logic [7:0]   pl [16];
        logic [127:0] held;
        logic [1:0]   md;
        logic [7:0]   junk;
        int e0, el;
        logic seen;

        bus.rx_pdata   = 8'h00;
        bus.rx_pdvalid = 1'b0;
        bus.blk_ready  = 1'b0;
        rst_n          = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_valid", 128'(bus.blk_valid), 128'(0));
        check_val("rst_busy",  128'(bus.busy), 128'(0));
        check_val("rst_pulse", 128'(bus.err_pulse), 128'(0));
        check_val("rst_code",  128'(bus.err_code), 128'(0));
        check_val("rst_data",  bus.blk_data, 128'(0));
        check_val("rst_mode",  128'(bus.blk_mode), 128'(0));
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Directed counting payload, encrypt mode
        for (int i = 0; i < 16; i++) pl[i] = 8'(i);
        send_frame(2'd0, pl, 1, 4, 3, "t1");
        accept_blk(2, "t1");

        // Long receiver level: one byte per assertion only
        rand_payload(pl);
        send_frame(2'd2, pl, 300, 300, 2, "t2");
        accept_blk(1, "t2");

        // Bad mode byte
        @(posedge clk); #1 e0 = err_hi;
        drive_byte(8'hA5, 3, 2);
        drive_byte(8'h07, 3, 2);
        repeat (3) @(posedge clk); #1;
        check_val("t3_err_cnt", 128'(err_hi - e0), 128'(1));
        check_val("t3_code",    128'(bus.err_code), 128'(1));
        check_val("t3_busy",    128'(bus.busy), 128'(0));
        rand_payload(pl);
        send_frame(2'd0, pl, 1, 6, 4, "t3");
        accept_blk(0, "t3");

        // Partial frame followed by silence
        @(posedge clk); #1 e0 = err_hi;
        drive_byte(8'hA5, 2, 1);
        drive_byte(8'h01, 2, 1);
        for (int i = 0; i < 5; i++) drive_byte(8'($urandom_range(255, 0)), 2, 1);
        seen = 1'b0;
        el   = 0;
        for (int i = 0; i < TMO_LIM + 100; i++) begin
            @(negedge clk);
            if (bus.err_pulse) begin
                seen = 1'b1;
                el   = cyc - last_set_cyc;
                break;
            end
        end
        check_val("t4_tmo_seen",   128'(seen), 128'(1));
        check_val("t4_tmo_window", 128'((el >= TMO_LIM) && (el <= TMO_LIM + 4)), 128'(1));
        @(posedge clk); #1;
        check_val("t4_code",    128'(bus.err_code), 128'(2));
        check_val("t4_busy",    128'(bus.busy), 128'(0));
        check_val("t4_err_cnt", 128'(err_hi - e0), 128'(1));
        rand_payload(pl);
        send_frame(2'd1, pl, 1, 5, 5, "t4");
        accept_blk(3, "t4");

        // Consumer stalls well past the timeout, then an overrun byte arrives
        rand_payload(pl);
        send_frame(2'd2, pl, 1, 3, 2, "t5");
        held = pack_blk(pl);
        @(posedge clk); #1 e0 = err_hi;
        repeat (1000) @(posedge clk);
        #1;
        check_val("t5_stall_valid", 128'(bus.blk_valid), 128'(1));
        check_val("t5_stall_errs",  128'(err_hi - e0), 128'(0));
        drive_byte(8'h3C, 4, 2);
        repeat (2) @(posedge clk); #1;
        check_val("t5_ovr_code",  128'(bus.err_code), 128'(3));
        check_val("t5_ovr_cnt",   128'(err_hi - e0), 128'(1));
        check_val("t5_ovr_data",  bus.blk_data, held);
        check_val("t5_ovr_valid", 128'(bus.blk_valid), 128'(1));
        accept_blk(1, "t5");

        // Accept and overrun in the same cycle; the dropped byte must not open a frame
        rand_payload(pl);
        send_frame(2'd1, pl, 1, 3, 2, "t5b");
        @(posedge clk); #1;
        e0 = err_hi;
        bus.blk_ready  = 1'b1;
        bus.rx_pdata   = 8'hA5;
        bus.rx_pdvalid = 1'b1;
        @(posedge clk); #1 bus.blk_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.rx_pdata   = 8'h00;
        bus.rx_pdvalid = 1'b0;
        @(negedge clk);
        check_val("t5b_valid",   128'(bus.blk_valid), 128'(0));
        check_val("t5b_busy",    128'(bus.busy), 128'(0));
        check_val("t5b_code",    128'(bus.err_code), 128'(3));
        check_val("t5b_err_cnt", 128'(err_hi - e0), 128'(1));
        rand_payload(pl);
        send_frame(2'd0, pl, 1, 3, 2, "t5c");
        accept_blk(0, "t5c");

        // Reset asserted while payload byte 9 is on the line
        rand_payload(pl);
        drive_byte(8'hA5, 2, 1);
        drive_byte(8'h02, 2, 1);
        for (int i = 0; i < 8; i++) drive_byte(pl[i], 2, 1);
        @(posedge clk); #1;
        bus.rx_pdata   = pl[8];
        bus.rx_pdvalid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_val("t6_busy",  128'(bus.busy), 128'(0));
        check_val("t6_valid", 128'(bus.blk_valid), 128'(0));
        check_val("t6_code",  128'(bus.err_code), 128'(0));
        check_val("t6_data",  bus.blk_data, 128'(0));
        bus.rx_pdata   = 8'h00;
        bus.rx_pdvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rand_payload(pl);
        send_frame(2'd2, pl, 1, 4, 3, "t6");

        // Reset while a block is held
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        check_val("t6b_valid", 128'(bus.blk_valid), 128'(0));
        check_val("t6b_busy",  128'(bus.busy), 128'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Randomized frames with junk bytes, occasional bad modes, random consumer delay
        for (int n = 0; n < 8; n++) begin
            repeat ($urandom_range(3, 0)) begin
                junk = 8'($urandom_range(255, 0));
                if (junk == 8'hA5) junk = 8'h5A;
                drive_byte(junk, $urandom_range(5, 1), $urandom_range(4, 0));
            end
            if ($urandom_range(3, 0) == 0) begin
                @(posedge clk); #1 e0 = err_hi;
                drive_byte(8'hA5, 2, 1);
                drive_byte(8'($urandom_range(255, 3)), 2, 1);
                repeat (2) @(posedge clk); #1;
                check_val("rnd_badmode_code", 128'(bus.err_code), 128'(1));
                check_val("rnd_badmode_cnt",  128'(err_hi - e0), 128'(1));
            end
            md = 2'($urandom_range(2, 0));
            rand_payload(pl);
            send_frame(md, pl, 1, 20, 10, "rnd");
            accept_blk($urandom_range(10, 0), "rnd");
        end

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
